btn_blip_bank: RTL

- Multi-channel button front end: synchronises, debounces and edge-detects N_CH raw pushbutton inputs.
- Emits one-cycle press (blip) and release (rel) pulses plus a clean level per channel.
- Sits between board pins and counter/control logic; supersedes single-channel blip detection.
- Adds metastability protection, a debounce filter and optional hold-to-repeat.

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_debounce_ch.sv | 107 ++++++++++
 rtl/btn_blip_bank.sv | 42 ++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button front end.
//   DEB_10MS_AT_100M   : debounce length giving 10 ms at 100 MHz
//   REP_DELAY_DEFAULT  : cycles from press blip to first repeat blip
//   REP_PERIOD_DEFAULT : cycles between subsequent repeat blips
//   cnt_width()        : ceil(log2(n)), never less than 1 bit
package btn_pkg;

    localparam int DEB_10MS_AT_100M   = 1_000_000;
    localparam int REP_DELAY_DEFAULT  = 50_000_000;
    localparam int REP_PERIOD_DEFAULT = 10_000_000;

    // Width of a counter that must hold values 0 .. n-1. Clamped to one bit
    // so n == 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        while ((64'd1 << w) < 64'(n)) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce filter, and
// registered one-cycle press (blip) / release (rel) pulses.
// Optional hold-to-repeat when BTN_REPEAT_EN is defined.
// Ports:
//   Clk100M : system clock, rising edge
//   Rst     : synchronous active-high reset
//   D       : raw asynchronous button input, active-high
//   level   : debounced button state
//   blip    : one-cycle pulse on accepted press (and on repeats)
//   rel     : one-cycle pulse on accepted release
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_10MS_AT_100M,
    parameter int REP_DELAY  = REP_DELAY_DEFAULT,
    parameter int REP_PERIOD = REP_PERIOD_DEFAULT
) (
    input  logic Clk100M,
    input  logic Rst,
    input  logic D,
    output logic level,
    output logic blip,
    output logic rel
);

    localparam int              CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_param
        $error("btn_debounce_ch: DEB_CYCLES, REP_DELAY and REP_PERIOD must be >= 1");
    end

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          accept;    // mismatch has persisted DEB_CYCLES cycles
    logic          rep_fire;  // repeat blip due this cycle

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge; blocking here would collapse
    // the two synchroniser stages into one.
    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= D;
            s2 <= s1;
        end
    end

    assign accept = (s2 != level) && (cnt == CNT_LAST);

    // Any return to agreement restarts the count, so glitches shorter than
    // DEB_CYCLES never reach CNT_LAST and the counter cannot wrap.
    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s2 == level) begin
            cnt   <= '0;
        end else if (accept) begin
            cnt   <= '0;
            level <= s2;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RW = cnt_width((REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD);

    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_last;
    logic          rep_first;  // still waiting for the longer initial delay

    assign rep_last = rep_first ? RW'(REP_DELAY - 1) : RW'(REP_PERIOD - 1);
    // Suppressed on the release-accept cycle so blip and rel never coincide.
    assign rep_fire = level && !accept && (rep_cnt == rep_last);

    // Held at zero while released; counting starts on the press-blip edge.
    always_ff @(posedge Clk100M) begin
        if (Rst || !level || accept) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt + RW'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            blip <= 1'b0;
            rel  <= 1'b0;
        end else begin
            blip <= (accept && s2) || rep_fire;
            rel  <= accept && !s2;
        end
    end

endmodule

// File: rtl/btn_blip_bank.sv
// Multi-channel button front end: N_CH independent copies of
// btn_debounce_ch with outputs concatenated per channel index.
// Optional hold-to-repeat is enabled by defining BTN_REPEAT_EN.
// Ports:
//   Clk100M : system clock, 100 MHz, rising edge
//   Rst     : synchronous active-high reset
//   D       : raw asynchronous button inputs [N_CH]
//   level   : debounced button states [N_CH]
//   blip    : one-cycle press (and repeat) pulses [N_CH]
//   rel     : one-cycle release pulses [N_CH]
module btn_blip_bank
    import btn_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int DEB_CYCLES = DEB_10MS_AT_100M,
    parameter int REP_DELAY  = REP_DELAY_DEFAULT,
    parameter int REP_PERIOD = REP_PERIOD_DEFAULT
) (
    input  logic            Clk100M,
    input  logic            Rst,
    input  logic [N_CH-1:0] D,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] blip,
    output logic [N_CH-1:0] rel
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
        ) u_ch (
            .Clk100M (Clk100M),
            .Rst     (Rst),
            .D       (D[i]),
            .level   (level[i]),
            .blip    (blip[i]),
            .rel     (rel[i])
        );
    end

endmodule
